// File: rtl/tensor_core_load_controller_if.sv
// Stream, register-file write and tensor-core handshake bundle for the load controller.
// The slave modport is the controller's view; the master modport is the surrounding system.
interface tensor_core_load_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_valid_in;
  logic                         data_ready_out;
  logic                         quad_write_enable_out;
  logic [2:0]                   quad_write_register_address_out;
  logic [3:0][DATA_WIDTH-1:0]   quad_write_data_out;
  logic                         compute_start_out;
  logic                         compute_done_in;

  modport slave (
    input  data_in, data_valid_in, compute_done_in,
    output data_ready_out, quad_write_enable_out, quad_write_register_address_out,
           quad_write_data_out, compute_start_out
  );

  modport master (
    output data_in, data_valid_in, compute_done_in,
    input  data_ready_out, quad_write_enable_out, quad_write_register_address_out,
           quad_write_data_out, compute_start_out
  );
endinterface

// File: rtl/tensor_core_load_controller.sv
// Packs an 18-byte operand stream into five quad register-file writes, starts the
// tensor core and waits for completion or timeout. All outputs are registered.
module tensor_core_load_controller #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  tensor_core_load_controller_if.slave  bus,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          error_out
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  localparam int             TW         = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT_CYCLES);
  localparam logic [4:0]     LAST_COUNT = 5'd18;

  state_e                     state_q, state_d;
  logic [4:0]                 count_q, count_d;
  logic [3:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic                       timeout_s;
  logic                       xfer_s;
  logic [4:0]                 last_idx_s;

  logic                       ready_q, ready_d;
  logic                       we_q, we_d;
  logic [2:0]                 addr_q, addr_d;
  logic [3:0][DATA_WIDTH-1:0] qdata_q, qdata_d;
  logic                       start_q, start_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  assign xfer_s = bus.data_valid_in && ready_q;

  // State and output registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      count_q <= 5'd0;
      buf_q   <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 3'd0;
      qdata_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      qdata_q <= qdata_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state, element packing and timeout counting
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    buf_d     = buf_q;
    tmo_d     = tmo_q;
    timeout_s = 1'b0;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (xfer_s) begin
          buf_d[count_q[1:0]] = bus.data_in;
          count_d             = count_q + 5'd1;
          if ((count_d[1:0] == 2'd0) || (count_d == LAST_COUNT)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        // Lanes must be zero so a short final quad carries zeros in its upper lanes
        buf_d   = '0;
        state_d = (count_q == LAST_COUNT) ? S_START : S_FILL;
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.compute_done_in) begin
          count_d = 5'd0;
          state_d = S_IDLE;
        end else if ((tmo_q + TW'(1)) == TMO_LAST) begin
          tmo_d     = tmo_q + TW'(1);
          timeout_s = 1'b1;
          count_d   = 5'd0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = 5'd0;
        buf_d   = '0;
      end
    endcase
  end

  // Output next values, decoded from the upcoming state
  always_comb begin
    last_idx_s = count_d - 5'd1;
    ready_d    = (state_d == S_IDLE) || (state_d == S_FILL);
    we_d       = (state_d == S_WRITE);
    start_d    = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_WAIT) && bus.compute_done_in;
    error_d    = error_q || timeout_s;
    if (state_d == S_WRITE) begin
      addr_d  = last_idx_s[4:2];
      qdata_d = buf_d;
    end else begin
      addr_d  = addr_q;
      qdata_d = qdata_q;
    end
  end

  assign bus.data_ready_out                  = ready_q;
  assign bus.quad_write_enable_out           = we_q;
  assign bus.quad_write_register_address_out = addr_q;
  assign bus.quad_write_data_out             = qdata_q;
  assign bus.compute_start_out               = start_q;
  assign busy_out                            = busy_q;
  assign done_out                            = done_q;
  assign error_out                           = error_q;
endmodule

// File: tb/tb_tensor_core_load_controller.sv
// Directed bench for tensor_core_load_controller: streams operands, checks quad writes,
// start/done/timeout behaviour and mid-operation reset.
module tb_tensor_core_load_controller;
  logic clock_in = 1'b0;
  logic reset_in;
  logic busy_out, done_out, error_out;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  stim [18];
  logic [2:0]  wq_addr [$];
  logic [31:0] wq_data [$];
  int          start_cnt;
  int          done_cnt;
  int          ready_in_write;

  tensor_core_load_controller_if #(.DATA_WIDTH(8)) bus ();

  tensor_core_load_controller #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(10)) dut (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .bus       (bus),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .error_out (error_out)
  );

  always #5 clock_in = ~clock_in;

  // Record strobes mid-cycle, away from the active edge
  always @(negedge clock_in) begin
    if (bus.quad_write_enable_out === 1'b1) begin
      wq_addr.push_back(bus.quad_write_register_address_out);
      wq_data.push_back(bus.quad_write_data_out);
      if (bus.data_ready_out !== 1'b0) ready_in_write++;
    end
    if (bus.compute_start_out === 1'b1) begin
      start_cnt++;
      if (bus.data_ready_out !== 1'b0) ready_in_write++;
    end
    if (done_out === 1'b1) done_cnt++;
  end

  function automatic logic [31:0] exp_quad(input int a);
    logic [31:0] q;
    q = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (4 * a + i < 18) q[8*i +: 8] = stim[4*a+i];
    end
    return q;
  endfunction

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    start_cnt      = 0;
    done_cnt       = 0;
    ready_in_write = 0;
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // Hold data valid until accepted; returns #1 after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    bus.data_in       = b;
    bus.data_valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clock_in);
      acc = bus.data_ready_out;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: byte %0h not accepted after %0d cycles", b, n);
    end
  endtask

  task automatic send_stream(input bit gap);
    for (int i = 0; i < 18; i++) begin
      send_byte(stim[i]);
      if (gap) begin
        bus.data_valid_in = 1'b0;
        step();
      end
    end
    bus.data_valid_in = 1'b0;
  endtask

  task automatic pulse_done_after(input int n);
    repeat (n) step();
    bus.compute_done_in = 1'b1;
    step();
    bus.compute_done_in = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset_in            = 1'b1;
    bus.data_valid_in   = 1'b0;
    bus.data_in         = 8'h00;
    bus.compute_done_in = 1'b0;
    repeat (3) step();
    reset_in = 1'b0;
    checks++;
    if ({bus.data_ready_out, busy_out, done_out, error_out, bus.quad_write_enable_out,
         bus.compute_start_out} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100000",
               {bus.data_ready_out, busy_out, done_out, error_out,
                bus.quad_write_enable_out, bus.compute_start_out});
    end
    checks++;
    if ({bus.quad_write_register_address_out, bus.quad_write_data_out} !== 35'h0) begin
      errors++;
      $display("FAIL reset_bus: addr %0d data %h expected 0", bus.quad_write_register_address_out,
               bus.quad_write_data_out);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int i = 0; i < 18; i++) stim[i] = 8'(i + 1);
    for (int i = 0; i < 18; i++) begin
      send_byte(stim[i]);
      if (i == 3) begin
        checks++;
        if (bus.quad_write_enable_out !== 1'b1 || bus.quad_write_data_out !== 32'h04030201) begin
          errors++;
          $display("FAIL b2b_first_write_latency: we %b data %h expected 1 04030201",
                   bus.quad_write_enable_out, bus.quad_write_data_out);
        end
      end
    end
    bus.data_valid_in = 1'b0;
    checks++;
    if (bus.quad_write_enable_out !== 1'b1 || bus.quad_write_register_address_out !== 3'd4 ||
        bus.quad_write_data_out !== 32'h00001211) begin
      errors++;
      $display("FAIL b2b_last_write: we %b addr %0d data %h expected 1 4 00001211",
               bus.quad_write_enable_out, bus.quad_write_register_address_out,
               bus.quad_write_data_out);
    end
    step();
    checks++;
    if (bus.compute_start_out !== 1'b1 || bus.quad_write_enable_out !== 1'b0 ||
        bus.quad_write_register_address_out !== 3'd4) begin
      errors++;
      $display("FAIL b2b_start_pulse: start %b we %b addr %0d expected 1 0 4",
               bus.compute_start_out, bus.quad_write_enable_out,
               bus.quad_write_register_address_out);
    end
    checks++;
    if (wq_data.size() !== 5) begin
      errors++;
      $display("FAIL b2b_write_count: got %0d expected 5", wq_data.size());
    end else begin
      for (int a = 0; a < 5; a++) begin
        checks++;
        if (wq_addr[a] !== 3'(a) || wq_data[a] !== exp_quad(a)) begin
          errors++;
          $display("FAIL b2b_quad: addr %0d data %h expected addr %0d data %h",
                   wq_addr[a], wq_data[a], a, exp_quad(a));
        end
      end
    end
  endtask

  // Entered in the start-pulse cycle left by test_back_to_back
  task automatic test_compute_done();
    repeat (7) step();
    checks++;
    if (busy_out !== 1'b1 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL done_pre: busy %b done %b expected 1 0", busy_out, done_out);
    end
    bus.compute_done_in = 1'b1;
    step();
    bus.compute_done_in = 1'b0;
    checks++;
    if (done_out !== 1'b1 || busy_out !== 1'b0 || bus.data_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done %b busy %b ready %b expected 1 0 1",
               done_out, busy_out, bus.data_ready_out);
    end
    repeat (3) step();
    checks++;
    if (done_cnt !== 1 || start_cnt !== 1 || error_out !== 1'b0) begin
      errors++;
      $display("FAIL done_once: done_cnt %0d start_cnt %0d error %b expected 1 1 0",
               done_cnt, start_cnt, error_out);
    end
  endtask

  task automatic test_gapped_valid();
    clear_mon();
    for (int i = 0; i < 18; i++) stim[i] = 8'(8'h20 + i);
    send_stream(1'b1);
    pulse_done_after(8);
    checks++;
    if (wq_data.size() !== 5 || start_cnt !== 1 || done_cnt !== 1 || ready_in_write !== 0) begin
      errors++;
      $display("FAIL gap_counts: writes %0d starts %0d dones %0d ready_hi %0d expected 5 1 1 0",
               wq_data.size(), start_cnt, done_cnt, ready_in_write);
    end else begin
      for (int a = 0; a < 5; a++) begin
        checks++;
        if (wq_addr[a] !== 3'(a) || wq_data[a] !== exp_quad(a)) begin
          errors++;
          $display("FAIL gap_quad: addr %0d data %h expected addr %0d data %h",
                   wq_addr[a], wq_data[a], a, exp_quad(a));
        end
      end
    end
  endtask

  task automatic test_negative_values();
    clear_mon();
    stim = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h40, 8'hC0, 8'h81,
             8'h7E, 8'hFD, 8'h03, 8'h9C, 8'h64, 8'hCE, 8'h32, 8'hF8, 8'h08};
    send_stream(1'b0);
    pulse_done_after(8);
    checks++;
    if (wq_data.size() !== 5) begin
      errors++;
      $display("FAIL neg_write_count: got %0d expected 5", wq_data.size());
    end else begin
      checks++;
      if (wq_data[0] !== 32'h00FF7F80 || wq_data[4] !== 32'h000008F8) begin
        errors++;
        $display("FAIL neg_signed_lanes: q0 %h q4 %h expected 00ff7f80 000008f8",
                 wq_data[0], wq_data[4]);
      end
      for (int a = 1; a < 4; a++) begin
        checks++;
        if (wq_data[a] !== exp_quad(a)) begin
          errors++;
          $display("FAIL neg_quad: addr %0d data %h expected %h", a, wq_data[a], exp_quad(a));
        end
      end
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    for (int i = 0; i < 18; i++) stim[i] = 8'(8'h40 + i);
    send_stream(1'b0);
    step();
    checks++;
    if (bus.compute_start_out !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start: start %b expected 1", bus.compute_start_out);
    end
    repeat (10) step();
    checks++;
    if (error_out !== 1'b0 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: error %b busy %b expected 0 1", error_out, busy_out);
    end
    step();
    checks++;
    if (error_out !== 1'b1 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: error %b busy %b done %b expected 1 0 0",
               error_out, busy_out, done_out);
    end
    clear_mon();
    for (int i = 0; i < 18; i++) stim[i] = 8'(8'h60 + i);
    send_stream(1'b0);
    pulse_done_after(8);
    checks++;
    if (done_cnt !== 1 || error_out !== 1'b1 || wq_data.size() !== 5) begin
      errors++;
      $display("FAIL tmo_recover: dones %0d error %b writes %0d expected 1 1 5",
               done_cnt, error_out, wq_data.size());
    end
  endtask

  task automatic test_reset_mid_operation();
    clear_mon();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i));
    bus.data_valid_in = 1'b0;
    step();
    clear_mon();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    checks++;
    if (error_out !== 1'b0 || busy_out !== 1'b0 || bus.data_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: error %b busy %b ready %b expected 0 0 1",
               error_out, busy_out, bus.data_ready_out);
    end
    repeat (5) step();
    checks++;
    if (wq_data.size() !== 0 || start_cnt !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: writes %0d starts %0d expected 0 0",
               wq_data.size(), start_cnt);
    end
    for (int i = 0; i < 18; i++) stim[i] = 8'(i + 1);
    send_stream(1'b0);
    pulse_done_after(8);
    checks++;
    if (wq_data.size() !== 5 || done_cnt !== 1) begin
      errors++;
      $display("FAIL mid_reset_restream: writes %0d dones %0d expected 5 1",
               wq_data.size(), done_cnt);
    end else begin
      checks++;
      if (wq_data[0] !== 32'h04030201 || wq_data[1] !== 32'h08070605) begin
        errors++;
        $display("FAIL mid_reset_stale: q0 %h q1 %h expected 04030201 08070605",
                 wq_data[0], wq_data[1]);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_back_to_back();
    test_compute_done();
    test_gapped_valid();
    test_negative_values();
    test_timeout();
    test_reset_mid_operation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
